adder_sum_accumulator: RTL and testbench

Downstream stage of the 4-bit ripple adder: consumes each 5-bit adder result ({carry, sum[3:0]}) under a valid/ready handshake and accumulates N_TERMS results into an ACC_W-bit accumulator. A finished total is held with out_valid until the consumer takes it, then the block re-arms. The block turns the combinational adder into a multi-term summing datapath driven from the top-level pins.

---
 rtl/adder_sum_accumulator.sv | 100 ++++++++++
 tb/tb_adder_sum_accumulator.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_sum_accumulator.sv
// Multi-term accumulator for 5-bit ripple-adder results with a valid/ready handshake on both sides.
// Define ACC_SATURATE_EN to clamp on overflow instead of wrapping modulo 2^ACC_W.
module adder_sum_accumulator #(
    parameter int N_TERMS = 16,
    parameter int ACC_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [4:0]       in_sum,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [4:0]       count,
    output logic             ovf
);

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(N_TERMS - 1);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [4:0]       count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W:0]   sum;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // The extra top bit of sum is the overflow indication for this term.
    assign sum = {1'b0, acc_q} + {{(ACC_W - 4){1'b0}}, in_sum};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (ena) begin
            if (clr) begin
                state_d = ST_ACC;
                acc_d   = '0;
                count_d = '0;
                ovf_d   = 1'b0;
            end else begin
                case (state_q)
                    ST_ACC: begin
                        if (in_valid) begin
                            ovf_d   = ovf_q | sum[ACC_W];
`ifdef ACC_SATURATE_EN
                            acc_d   = (ovf_q || sum[ACC_W]) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
                            acc_d   = sum[ACC_W-1:0];
`endif
                            count_d = count_q + 5'd1;
                            if (count_q == LAST_IDX) begin
                                state_d = ST_DONE;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (out_ready) begin
                            state_d = ST_ACC;
                            acc_d   = '0;
                            count_d = '0;
                            ovf_d   = 1'b0;
                        end
                    end
                    default: state_d = ST_ACC;
                endcase
            end
        end
    end

    always_comb begin
        in_ready  = (state_q == ST_ACC);
        out_valid = (state_q == ST_DONE);
        acc_out   = acc_q;
        count     = count_q;
        ovf       = ovf_q;
    end

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Scoreboard bench for adder_sum_accumulator: a 16-term instance for most scenarios and a 2-term instance.
// Completed totals are checked by monitors at each output transfer; intermediate state is checked directly.
module tb_adder_sum_accumulator;

    typedef struct {
        logic [15:0] acc;
        logic [4:0]  cnt;
        logic        ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n, ena, clr;
    logic       in_valid, out_ready;
    logic [4:0] in_sum;
    logic       in_ready, out_valid, ovf;
    logic [7:0] acc_out;
    logic [4:0] count;

    logic       b_in_valid, b_out_ready;
    logic [4:0] b_in_sum;
    logic       b_in_ready, b_out_valid, b_ovf;
    logic [7:0] b_acc_out;
    logic [4:0] b_count;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t b_exp_q[$];

`ifdef ACC_SATURATE_EN
    localparam int FULL_31 = 255;
`else
    localparam int FULL_31 = 240;
`endif

    adder_sum_accumulator #(.N_TERMS(16), .ACC_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr),
        .in_valid(in_valid), .in_sum(in_sum), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .acc_out(acc_out), .count(count), .ovf(ovf)
    );

    adder_sum_accumulator #(.N_TERMS(2), .ACC_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr),
        .in_valid(b_in_valid), .in_sum(b_in_sum), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .acc_out(b_acc_out), .count(b_count), .ovf(b_ovf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] s);
        in_valid = v;
        in_sum   = s;
        step();
    endtask

    task automatic check_state(input string name, input int acc, input int cnt, input int ov,
                               input int rdy, input int vld);
        checkOutput({name, "_acc"}, 32'(acc_out), 32'(acc));
        checkOutput({name, "_count"}, 32'(count), 32'(cnt));
        checkOutput({name, "_ovf"}, 32'(ovf), 32'(ov));
        checkOutput({name, "_in_ready"}, 32'(in_ready), 32'(rdy));
        checkOutput({name, "_out_valid"}, 32'(out_valid), 32'(vld));
    endtask

    // Monitors: sample on the falling edge whether the next rising edge performs an output transfer.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ena && !clr && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_transfer: got acc %0d, expected no transfer", acc_out);
            end else begin
                e = exp_q.pop_front();
                checkOutput("xfer_acc", 32'(acc_out), 32'(e.acc));
                checkOutput("xfer_count", 32'(count), 32'(e.cnt));
                checkOutput("xfer_ovf", 32'(ovf), 32'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ena && !clr && b_out_valid && b_out_ready) begin
            if (b_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_transfer_n2: got acc %0d, expected no transfer", b_acc_out);
            end else begin
                e = b_exp_q.pop_front();
                checkOutput("xfer_n2_acc", 32'(b_acc_out), 32'(e.acc));
                checkOutput("xfer_n2_count", 32'(b_count), 32'(e.cnt));
                checkOutput("xfer_n2_ovf", 32'(b_ovf), 32'(e.ovf));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; ena = 1'b1; clr = 1'b0;
        in_valid = 1'b0; in_sum = '0; out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_sum = '0; b_out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        check_state("reset", 0, 0, 0, 1, 0);

        // Four terms with continuous valid; total not yet complete.
        applyStimulus(1'b1, 5'd15);
        applyStimulus(1'b1, 5'd31);
        applyStimulus(1'b1, 5'd1);
        applyStimulus(1'b1, 5'd0);
        in_valid = 1'b0;
        check_state("four_terms", 47, 4, 0, 1, 0);

        // Two-term instance: completes, ignores input in DONE, restarts from zero.
        b_in_valid = 1'b1; b_in_sum = 5'd10;
        step();
        b_in_sum = 5'd20;
        step();
        b_in_sum = 5'd5;
        checkOutput("n2_done_valid", 32'(b_out_valid), 32'd1);
        checkOutput("n2_done_acc", 32'(b_acc_out), 32'd30);
        checkOutput("n2_done_count", 32'(b_count), 32'd2);
        checkOutput("n2_done_in_ready", 32'(b_in_ready), 32'd0);
        b_exp_q.push_back('{acc: 16'd30, cnt: 5'd2, ovf: 1'b0});
        step();
        step();
        checkOutput("n2_ignore_acc", 32'(b_acc_out), 32'd30);
        b_out_ready = 1'b1;
        step();
        b_out_ready = 1'b0;
        checkOutput("n2_rearm_acc", 32'(b_acc_out), 32'd0);
        checkOutput("n2_rearm_ready", 32'(b_in_ready), 32'd1);
        step();
        b_in_valid = 1'b0;
        checkOutput("n2_next_acc", 32'(b_acc_out), 32'd5);
        checkOutput("n2_next_count", 32'(b_count), 32'd1);

        // Clear drops a concurrent term.
        clr = 1'b1;
        step();
        clr = 1'b0;
        check_state("clr_idle", 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 5'd7);
        check_state("three_sevens", 21, 3, 0, 1, 0);
        clr = 1'b1;
        applyStimulus(1'b1, 5'd9);
        clr = 1'b0;
        in_valid = 1'b0;
        check_state("clr_drop", 0, 0, 0, 1, 0);

        // Enable low freezes state; accepts resume afterwards.
        applyStimulus(1'b1, 5'd6);
        applyStimulus(1'b1, 5'd6);
        check_state("two_sixes", 12, 2, 0, 1, 0);
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'd5);
            check_state("ena_hold", 12, 2, 0, 1, 0);
        end
        ena = 1'b1;
        applyStimulus(1'b1, 5'd5);
        in_valid = 1'b0;
        check_state("ena_resume", 17, 3, 0, 1, 0);
        clr = 1'b1;
        step();
        clr = 1'b0;

        // Sixteen maximal terms: overflow, DONE hold, then transfer.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 5'd31);
            if (i == 14) checkOutput("pre_done_valid", 32'(out_valid), 32'd0);
        end
        check_state("full_done", FULL_31, 16, 1, 0, 1);
        exp_q.push_back('{acc: 16'(FULL_31), cnt: 5'd16, ovf: 1'b1});
        for (int i = 0; i < 5; i++) begin
            step();
            check_state("done_hold", FULL_31, 16, 1, 0, 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_state("after_xfer", 0, 0, 0, 1, 0);

        // Reset while DONE with out_ready high: no transfer, reset values.
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 5'd1);
        in_valid = 1'b0;
        check_state("ones_done", 16, 16, 0, 0, 1);
        rst_n = 1'b0;
        out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        out_ready = 1'b0;
        check_state("reset_in_done", 0, 0, 0, 1, 0);

        // Single-edge reset mid-total.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 5'd2);
        in_valid = 1'b0;
        check_state("three_twos", 6, 3, 0, 1, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_state("reset_mid", 0, 0, 0, 1, 0);

        step();
        step();
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("scoreboard_n2_drained", 32'(b_exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
